image_load_block: RTL and testbench

Loads a square feature map of up to 32x32 signed 16-bit words from memory into a flat 1024-entry register array. It fetches the map through the shared DMA port, which returns 25 consecutive words per read. It sits between the DMA memory and the CNN controller. The controller supplies the image base address and size, raises `enable`, waits for `done`, then consumes `out` as the fetched image.

---
 rtl/image_load_if.sv | 21 ++
 rtl/image_load_block.sv | 111 +++++++++++
 tb/tb_image_load_block.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/image_load_if.sv
// Controller/DMA-facing bundle of the image loader: load request, geometry,
// DMA burst port and the flat loaded-image array.
interface image_load_if;
   logic                enable;
   logic        [15:0]  size;
   logic        [15:0]  address;
   logic signed [15:0]  dmaOut [25];
   logic        [15:0]  dmaAddr;
   logic signed [15:0]  out [1024];
   logic                done;

   modport slave (
      input  enable, size, address, dmaOut,
      output dmaAddr, out, done
   );

   modport master (
      output enable, size, address, dmaOut,
      input  dmaAddr, out, done
   );
endinterface

// File: rtl/image_load_block.sv
// Fetches an SxS signed 16-bit feature map (S*S clamped to 1024) into a flat
// register array, one 25-word DMA burst every two cycles (REQ then CAP).
module image_load_block (
   input  logic         clk,
   input  logic         reset,
   image_load_if.slave  bus
);
   localparam int unsigned BURST = 25;
   localparam int unsigned DEPTH = 1024;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAP, S_DONE} state_t;

   state_t              r_state;
   logic        [15:0]  r_dma_addr;
   logic        [10:0]  r_n;
   logic        [10:0]  r_base;
   logic                r_done;
   logic signed [15:0]  r_out [DEPTH];

   logic        [31:0]  w_sq;
   logic        [10:0]  w_n;
   logic        [10:0]  w_next_base;
   logic                w_more;
   logic        [10:0]  w_idx [BURST];
   logic   [BURST-1:0]  w_wr;

   // Full 32-bit square so large sizes clamp instead of wrapping.
   assign w_sq        = 32'(bus.size) * 32'(bus.size);
   assign w_n         = (w_sq > 32'(DEPTH)) ? 11'(DEPTH) : w_sq[10:0];
   assign w_next_base = r_base + 11'(BURST);
   assign w_more      = (w_next_base < r_n);

   // NOTE: every element is assigned on every pass, so no latch can be inferred.
   always_comb begin
      for (int i = 0; i < BURST; i++) begin
         w_idx[i] = r_base + 11'(i);
         w_wr[i]  = (r_state == S_CAP) && (w_idx[i] < r_n);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_done     <= 1'b0;
         r_dma_addr <= '0;
         r_n        <= '0;
         r_base     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.enable) begin
                  if (w_n == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_n        <= w_n;
                     r_base     <= '0;
                     r_dma_addr <= bus.address;
                     r_state    <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               r_state <= bus.enable ? S_CAP : S_IDLE;
            end
            S_CAP: begin
               // The capture itself happens regardless; enable only picks the exit.
               if (!bus.enable) begin
                  r_state <= S_IDLE;
               end else if (w_more) begin
                  r_base     <= w_next_base;
                  r_dma_addr <= r_dma_addr + 16'(BURST);
                  r_state    <= S_REQ;
               end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               if (!bus.enable) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: the image array is a register file, not a RAM, so it is cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out <= '{default: '0};
      end else begin
         for (int i = 0; i < BURST; i++) begin
            if (w_wr[i]) begin
               r_out[w_idx[i][9:0]] <= bus.dmaOut[i];
            end
         end
      end
   end

   assign bus.dmaAddr = r_dma_addr;
   assign bus.done    = r_done;
   assign bus.out     = r_out;
endmodule

// File: tb/tb_image_load_block.sv
// Directed plus randomized bench for image_load_block: plays controller and a
// registered 25-word DMA, and checks against an array-level reference model.
module tb_image_load_block;
   logic clk = 1'b0;
   logic reset;

   image_load_if bus ();

   image_load_block dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic signed [15:0] mem     [65536];
   logic signed [15:0] exp_out [1024];
   int checks   = 0;
   int failures = 0;

   function automatic logic signed [15:0] mem_at(input logic [15:0] a);
      return mem[a];
   endfunction

   // Registered DMA: samples dmaAddr on each edge, data valid the following cycle.
   always @(posedge clk) begin
      for (int i = 0; i < 25; i++) begin
         bus.dmaOut[i] <= mem_at(bus.dmaAddr + 16'(i));
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_array(input string tag);
      int bad = 0;
      for (int j = 0; j < 1024; j++) begin
         if (bus.out[j] !== exp_out[j]) bad++;
      end
      check({tag, " out mismatches"}, bad, 0);
   endtask

   task automatic clear_model;
      for (int j = 0; j < 1024; j++) exp_out[j] = '0;
   endtask

   task automatic do_reset(input string tag);
      reset      = 1'b1;
      bus.enable = 1'b0;
      tick;
      tick;
      reset = 1'b0;
      clear_model();
      check({tag, " done after reset"}, 32'(bus.done), 0);
      check({tag, " dmaAddr after reset"}, 32'(bus.dmaAddr), 0);
      check_array({tag, " after reset"});
   endtask

   // Full load with enable held; checks burst addresses, done latency, image, done fall.
   task automatic run_load(input logic [15:0] s, input logic [15:0] a, input string tag);
      longint      sq;
      int          n, b, want, got;
      logic [15:0] prev_addr, exp_addr;
      sq   = longint'(s) * longint'(s);
      n    = (sq > 1024) ? 1024 : int'(sq);
      b    = (n + 24) / 25;
      want = (n == 0) ? 1 : 2 * b + 1;
      prev_addr   = bus.dmaAddr;
      bus.size    = s;
      bus.address = a;
      bus.enable  = 1'b1;
      got = 0;
      for (int c = 1; c <= 120 && got == 0; c++) begin
         tick;
         if (n > 0 && (c % 2) == 1 && c < 2 * b) begin
            exp_addr = a + 16'(25 * ((c - 1) / 2));
            check({tag, " dmaAddr"}, 32'(bus.dmaAddr), 32'(exp_addr));
         end
         if (bus.done === 1'b1) got = c;
      end
      check({tag, " done latency"}, got, want);
      if (n == 0) check({tag, " dmaAddr held"}, 32'(bus.dmaAddr), 32'(prev_addr));
      for (int k = 0; k < n; k++) exp_out[k] = mem_at(a + 16'(k));
      check_array(tag);
      bus.size    = ~s;
      bus.address = ~a;
      tick;
      check({tag, " done held"}, 32'(bus.done), 1);
      check_array({tag, " held in DONE"});
      bus.enable = 1'b0;
      tick;
      check({tag, " done fall"}, 32'(bus.done), 0);
   endtask

   initial begin
      logic [15:0] a, exp_addr;
      logic [15:0] s;
      reset       = 1'b1;
      bus.enable  = 1'b0;
      bus.size    = '0;
      bus.address = '0;
      for (int j = 0; j < 65536; j++) mem[j] = 16'(j);

      do_reset("init");

      run_load(16'd5, 16'd100, "s5");
      check("s5 out[0]", 32'({bus.out[0]}), 32'd100);
      check("s5 out[24]", 32'({bus.out[24]}), 32'd124);
      check("s5 out[25]", 32'({bus.out[25]}), 32'd0);

      run_load(16'd6, 16'd200, "s6");
      check("s6 out[35]", 32'({bus.out[35]}), 32'd235);
      check("s6 out[36]", 32'({bus.out[36]}), 32'd0);

      run_load(16'd32, 16'd50704, "s32");
      check("s32 last dmaAddr", 32'(bus.dmaAddr), 32'd51704);
      check("s32 out[1023]", 32'({bus.out[1023]}), 32'd51727);

      run_load(16'd0, 16'd7, "s0");

      // Abort in the CAP of burst 3: bursts 0..3 land, the rest keeps old contents.
      a           = 16'd3000;
      bus.size    = 16'd32;
      bus.address = a;
      bus.enable  = 1'b1;
      for (int c = 1; c <= 8; c++) tick;
      exp_addr = a + 16'd75;
      check("abort dmaAddr in CAP3", 32'(bus.dmaAddr), 32'(exp_addr));
      check("abort done low before drop", 32'(bus.done), 0);
      bus.enable = 1'b0;
      tick;
      for (int k = 0; k < 100; k++) exp_out[k] = mem_at(a + 16'(k));
      tick;
      tick;
      check("abort done stays low", 32'(bus.done), 0);
      check_array("abort");
      run_load(16'd5, 16'd400, "after abort");

      // Reset in the middle of a 32x32 load.
      bus.size    = 16'd32;
      bus.address = 16'd9000;
      bus.enable  = 1'b1;
      for (int c = 1; c <= 11; c++) tick;
      do_reset("midload");

      run_load(16'd5, 16'hFFF0, "wrap");
      check("wrap out[16]", 32'({bus.out[16]}), 32'd0);
      do_reset("post wrap");

      // Randomized phase: fresh memory contents, random geometry and base.
      for (int j = 0; j < 65536; j++) mem[j] = 16'($urandom);
      for (int t = 0; t < 8; t++) begin
         s = (t == 3) ? 16'hFFFF : 16'($urandom_range(0, 34));
         a = 16'($urandom);
         run_load(s, a, $sformatf("rand%0d", t));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
